// File: rtl/sync_counter_pkg.sv
// Shared types and constants for the synchronous counter subsystem.
// State encoding and the default prescale divider.
package sync_counter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        DONE  = 2'b11
    } state_t;

    localparam int PRESCALE_DEF = 4;

endpackage

// File: rtl/sync_counter_ctrl_prescaler.sv
// Advance divider for sync_counter_ctrl.
// tick is high on enabled cycles where the divider sits at PRESCALE-1.
module scc_prescaler
    import sync_counter_pkg::*;
#(
    parameter int PRESCALE = PRESCALE_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clear,
    output logic tick
);

    localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] cnt;

    assign tick = en && (cnt == LAST);

    // divider: restarts on clear, wraps after the tick cycle
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/sync_counter_ctrl.sv
// Counter register and start/pause/load/clear sequencer.
// Optional advance prescaler enabled by defining SCC_PRESCALE_EN.
module sync_counter_ctrl
    import sync_counter_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int PRESCALE = PRESCALE_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             start,
    input  logic             stop,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] limit,
    input  logic             oneshot,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             tc,
    output logic             done
);

    state_t           state;
    state_t           state_n;
    logic [WIDTH-1:0] limit_q;
    logic             mode_q;
    logic [WIDTH-1:0] count_n;
    logic [WIDTH-1:0] limit_n;
    logic             mode_n;
    logic             tc_n;
    logic             adv;
    logic             hit;

    assign hit = (count == limit_q);

`ifdef SCC_PRESCALE_EN
    logic tick;
    logic pre_en;
    logic pre_clr;

    // stop/load/clr cycles never count toward the next advance
    assign pre_en  = (state == RUN) && !clr && !load && !stop;
    assign pre_clr = clr || load ||
                     (start && (state == IDLE || state == DONE));

    scc_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk   (clk),
        .rst   (rst),
        .en    (pre_en),
        .clear (pre_clr),
        .tick  (tick)
    );

    assign adv = tick;
`else
    assign adv = 1'b1;
`endif

    // state and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            count   <= '0;
            limit_q <= '0;
            mode_q  <= 1'b0;
            busy    <= 1'b0;
            tc      <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_n;
            count   <= count_n;
            limit_q <= limit_n;
            mode_q  <= mode_n;
            busy    <= (state_n == RUN) || (state_n == PAUSE);
            tc      <= tc_n;
            done    <= (state_n == DONE);
        end
    end

    // next-state decode: clr > load > stop > start
    always_comb begin
        state_n = state;
        if (clr) begin
            state_n = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) state_n = RUN;
                end
                RUN: begin
                    if (load) state_n = RUN;
                    else if (stop) state_n = PAUSE;
                    else if (adv && hit && mode_q) state_n = DONE;
                end
                PAUSE: begin
                    if (!load && start) state_n = RUN;
                end
                DONE: begin
                    if (load) state_n = IDLE;
                    else if (start) state_n = RUN;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // count, sampled config and terminal-count pulse
    always_comb begin
        count_n = count;
        limit_n = limit_q;
        mode_n  = mode_q;
        tc_n    = 1'b0;
        if (clr) begin
            count_n = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (load) count_n = load_val;
                    if (start) begin
                        limit_n = limit;
                        mode_n  = oneshot;
                    end
                end
                RUN: begin
                    if (load) begin
                        count_n = load_val;
                    end else if (!stop && adv) begin
                        if (!hit) begin
                            count_n = count + 1'b1;
                        end else begin
                            tc_n = 1'b1;
                            if (!mode_q) count_n = '0;
                        end
                    end
                end
                PAUSE: begin
                    if (load) count_n = load_val;
                end
                DONE: begin
                    if (load) begin
                        count_n = load_val;
                    end else if (start) begin
                        count_n = '0;
                        limit_n = limit;
                        mode_n  = oneshot;
                    end
                end
                default: count_n = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_sync_counter_ctrl.sv
// Directed bench for sync_counter_ctrl at WIDTH=4.
// Expected values are hand-computed per step.
module tb_sync_counter_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       clr = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_val = '0;
    logic [3:0] limit = '0;
    logic       oneshot = 1'b0;
    logic [3:0] count;
    logic       busy;
    logic       tc;
    logic       done;

    int vecs = 0;
    int errs = 0;

    sync_counter_ctrl #(
        .WIDTH    (4),
        .PRESCALE (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .start    (start),
        .stop     (stop),
        .load     (load),
        .load_val (load_val),
        .limit    (limit),
        .oneshot  (oneshot),
        .count    (count),
        .busy     (busy),
        .tc       (tc),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic step(
        input logic       r,
        input logic       c,
        input logic       s,
        input logic       p,
        input logic       l,
        input logic [3:0] lv,
        input string      tag,
        input logic [3:0] ec,
        input logic       eb,
        input logic       et,
        input logic       ed
    );
        rst      = r;
        clr      = c;
        start    = s;
        stop     = p;
        load     = l;
        load_val = lv;
        @(posedge clk);
        #1;
        vecs++;
        assert ({count, busy, tc, done} === {ec, eb, et, ed})
        else begin
            errs++;
            $error("FAIL %s: observed count=%0d busy=%b tc=%b done=%b expected count=%0d busy=%b tc=%b done=%b",
                   tag, count, busy, tc, done, ec, eb, et, ed);
        end
    endtask

    initial begin
        @(negedge clk);
        step(1, 0, 0, 0, 0, 0, "reset", 0, 0, 0, 0);
`ifndef SCC_PRESCALE_EN
        // free-run to limit 5
        limit   = 5;
        oneshot = 0;
        step(0, 0, 1, 0, 0, 0, "fr_start", 0, 1, 0, 0);
        for (int i = 1; i <= 5; i++)
            step(0, 0, 0, 0, 0, 0, "fr_inc", 4'(i), 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, "fr_wrap", 0, 1, 1, 0);
        step(0, 0, 0, 0, 0, 0, "fr_post1", 1, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, "fr_post2", 2, 1, 0, 0);
        // pause at 2, limit change ignored
        step(0, 0, 0, 1, 0, 0, "pause", 2, 1, 0, 0);
        limit = 2;
        for (int i = 0; i < 5; i++)
            step(0, 0, 0, 0, 0, 0, "pause_hold", 2, 1, 0, 0);
        step(0, 0, 1, 0, 0, 0, "resume", 2, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, "res_3", 3, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, "res_4", 4, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, "res_5", 5, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, "res_wrap", 0, 1, 1, 0);
        // load above limit wraps through 15
        step(0, 0, 0, 0, 1, 14, "run_load", 14, 1, 0, 0);
        for (int i = 0; i < 7; i++)
            step(0, 0, 0, 0, 0, 0, "ld_wrap", 4'(15 + i), 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, "ld_tc", 0, 1, 1, 0);
        // clr beats load and start
        step(0, 1, 1, 0, 1, 9, "clr_prio", 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, "idle_hold", 0, 0, 0, 0);
        // one-shot to 3, then restart
        limit   = 3;
        oneshot = 1;
        step(0, 0, 1, 0, 0, 0, "os_start", 0, 1, 0, 0);
        for (int i = 1; i <= 3; i++)
            step(0, 0, 0, 0, 0, 0, "os_inc", 4'(i), 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, "os_done", 3, 0, 1, 1);
        step(0, 0, 0, 0, 0, 0, "os_hold", 3, 0, 0, 1);
        step(0, 0, 1, 0, 0, 0, "os_restart", 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, "os_re1", 1, 1, 0, 0);
        // reset mid-run beats everything
        step(0, 1, 0, 0, 0, 0, "clr", 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 8, "idle_load", 8, 0, 0, 0);
        limit   = 12;
        oneshot = 0;
        step(0, 0, 1, 0, 0, 0, "start8", 8, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, "run9", 9, 1, 0, 0);
        step(1, 0, 1, 0, 1, 3, "rst_mid", 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, "post_rst", 0, 0, 0, 0);
        // limit 0 free-run: tc every cycle
        limit = 0;
        step(0, 0, 1, 0, 0, 0, "z_start", 0, 1, 0, 0);
        for (int i = 0; i < 3; i++)
            step(0, 0, 0, 0, 0, 0, "z_tc", 0, 1, 1, 0);
        // limit 0 one-shot, then load out of DONE
        step(0, 1, 0, 0, 0, 0, "clr2", 0, 0, 0, 0);
        oneshot = 1;
        step(0, 0, 1, 0, 0, 0, "zos_start", 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, "zos_done", 0, 0, 1, 1);
        step(0, 0, 0, 0, 1, 7, "done_load", 7, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, "idle7", 7, 0, 0, 0);
`else
        // advance every 4th RUN cycle, pause keeps phase
        limit   = 9;
        oneshot = 0;
        step(0, 0, 1, 0, 0, 0, "ps_start", 0, 1, 0, 0);
        for (int i = 0; i < 3; i++)
            step(0, 0, 0, 0, 0, 0, "ps_wait", 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, "ps_adv1", 1, 1, 0, 0);
        for (int i = 0; i < 2; i++)
            step(0, 0, 0, 0, 0, 0, "ps_mid", 1, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0, "ps_stop", 1, 1, 0, 0);
        for (int i = 0; i < 3; i++)
            step(0, 0, 0, 0, 0, 0, "ps_hold", 1, 1, 0, 0);
        step(0, 0, 1, 0, 0, 0, "ps_resume", 1, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, "ps_rem", 1, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, "ps_adv2", 2, 1, 0, 0);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/sync_counter_ctrl.md
Name: sync_counter_ctrl

Overview:
Controller and counter register for a WIDTH-bit synchronous binary counter. Sequences start/pause/resume/clear/load, detects terminal count against a programmable limit, and supports free-running (wrap) and one-shot (stop at limit) modes. It is the top-level sequencing block of the synchronous counter subsystem and feeds count and status to downstream logic.

Parameters:
WIDTH, 8, counter and limit width in bits
PRESCALE, 4, advance divider; used only when SCC_PRESCALE_EN is defined; legal range 2..255

Ports:
clk  input  1  clock; all state changes on the rising edge
rst  input  1  reset, synchronous and active-high
clr  input  1  synchronous clear: count to 0, go to IDLE
start  input  1  start from IDLE/DONE, or resume from PAUSE
stop  input  1  pause while RUN
load  input  1  parallel load of load_val into count
load_val  input  WIDTH  value for load
limit  input  WIDTH  terminal value; sampled into limit_q on start
oneshot  input  1  mode select, sampled on start: 1 = one-shot, 0 = free-run
count  output  WIDTH  current count, registered
busy  output  1  high in RUN and PAUSE, registered
tc  output  1  one-cycle terminal-count pulse, registered
done  output  1  high in DONE (one-shot complete), registered

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset: state=IDLE, count=0, limit_q=0, mode_q=0, busy=0, tc=0, done=0.
- Per-cycle priority: rst > clr > load > stop > start.
- States are IDLE, RUN, PAUSE, DONE.
- clr (any state): count<=0, state<=IDLE, tc<=0, done<=0.
- IDLE:
  - load: count<=load_val.
  - start: limit_q<=limit, mode_q<=oneshot, state<=RUN; count<=load_val if load is also high, otherwise count is unchanged.
- RUN: on each advance cycle:
  - count!=limit_q: count<=count+1, modulo 2^WIDTH.
  - count==limit_q and mode_q=0: count<=0 and tc<=1 for exactly one cycle.
  - count==limit_q and mode_q=1: count holds, state<=DONE, tc<=1 for one cycle, done<=1.
- RUN with stop: state<=PAUSE and count holds; no advance occurs in that cycle.
- RUN with load: count<=load_val and state stays RUN; load replaces the advance in that cycle.
- PAUSE:
  - count holds.
  - start: state<=RUN; limit_q and mode_q are not resampled.
  - load: count<=load_val.
- DONE:
  - count holds at limit_q and done=1.
  - start: count<=0, resample limit_q and mode_q, state<=RUN, done<=0.
  - load: count<=load_val, state<=IDLE, done<=0.
- busy=1 exactly when the next state is RUN or PAUSE; it is registered alongside state.
- Terminal detection is by equality with limit_q. A load above limit_q wraps through 2^WIDTH-1 to 0, then reaches limit_q.
- limit_q=0:
  - Free-run: count stays 0 and tc=1 on every advance cycle.
  - One-shot: DONE after the first advance cycle.
- Changes to limit or oneshot during RUN/PAUSE are ignored until the next start from IDLE or DONE.
- Latency: count changes on the edge after the qualifying input. tc and done rise on the same edge as the terminal transition.

Optional Feature:
- Macro: SCC_PRESCALE_EN.
- Defined:
  - An internal prescaler advances count only on cycles where the prescaler is at PRESCALE-1; it then wraps to 0.
  - The prescaler runs only in RUN. It holds in PAUSE.
  - It resets to 0 on rst, clr, load, and on start from IDLE or DONE.
  - tc stays a single-clk-cycle pulse.
- Undefined: every RUN cycle is an advance cycle and no prescaler logic exists.

Decomposition:
- Shared package sync_counter_pkg holds:
  - the state typedef, encoded IDLE=2'b00, RUN=2'b01, PAUSE=2'b10, DONE=2'b11;
  - the PRESCALE default constant.
- One natural sub-module, scc_prescaler: enable, clear and tick output; instantiated only under SCC_PRESCALE_EN.
- The FSM and the count register stay in sync_counter_ctrl.

Test Plan:
- Free-run: WIDTH=4, limit=5, oneshot=0, start pulse from count 0 -> count 1,2,3,4,5,0,1…; tc high only in the cycle count shows 0 after 5; busy=1 throughout.
- One-shot: limit=3, oneshot=1, start -> count 1,2,3 then holds 3; done=1 and busy=0 from the cycle count reaches its final state, tc one pulse; a second start -> count 0,1,…
- Pause/resume: stop when count=2 -> count holds 2 for 5 cycles, busy=1; start -> 3; changing limit mid-pause has no effect.
- Priority and load: clr+load+start in the same cycle -> count=0, IDLE; load_val=14 in RUN with limit=5 -> 14,15,0,…,5 then tc.
- Reset mid-operation: rst while RUN at count=9 -> next cycle count=0, IDLE, busy=tc=done=0; limit=0 free-run -> tc high every cycle, count stays 0.
- With SCC_PRESCALE_EN and PRESCALE=4: count advances every 4th RUN cycle; stop mid-interval then resume completes the remaining cycles before the next advance.
